// File: rtl/rob_commit_ctrl_if.sv
// Dispatcher, CDB and register-file signals of the reorder buffer.
// The ROB side uses the slave modport; its environment uses master.
interface rob_commit_ctrl_if;
  logic        alloc_valid_from_dispatcher;
  logic [4:0]  alloc_rd_from_dispatcher;
  logic        alloc_is_branch_from_dispatcher;
  logic        alloc_pred_taken_from_dispatcher;
  logic [31:0] alloc_alt_pc_from_dispatcher;
  logic        full_to_dispatcher;
  logic [4:0]  alloc_tag_to_dispatcher;

  logic        wb_valid_from_cdb;
  logic [4:0]  wb_tag_from_cdb;
  logic [31:0] wb_value_from_cdb;
  logic        wb_taken_from_cdb;

  logic [4:0]  query_tag1_from_dispatcher;
  logic [4:0]  query_tag2_from_dispatcher;
  logic        query_ready1_to_dispatcher;
  logic        query_ready2_to_dispatcher;
  logic [31:0] query_value1_to_dispatcher;
  logic [31:0] query_value2_to_dispatcher;

  logic        commit_flag_to_regfile;
  logic [4:0]  rd_to_regfile;
  logic [4:0]  Q_to_regfile;
  logic [31:0] V_to_regfile;
  logic        rollback_flag_to_regfile;
  logic [31:0] rollback_pc_to_fetch;

  modport slave (
    input  alloc_valid_from_dispatcher,
    input  alloc_rd_from_dispatcher,
    input  alloc_is_branch_from_dispatcher,
    input  alloc_pred_taken_from_dispatcher,
    input  alloc_alt_pc_from_dispatcher,
    output full_to_dispatcher,
    output alloc_tag_to_dispatcher,
    input  wb_valid_from_cdb,
    input  wb_tag_from_cdb,
    input  wb_value_from_cdb,
    input  wb_taken_from_cdb,
    input  query_tag1_from_dispatcher,
    input  query_tag2_from_dispatcher,
    output query_ready1_to_dispatcher,
    output query_ready2_to_dispatcher,
    output query_value1_to_dispatcher,
    output query_value2_to_dispatcher,
    output commit_flag_to_regfile,
    output rd_to_regfile,
    output Q_to_regfile,
    output V_to_regfile,
    output rollback_flag_to_regfile,
    output rollback_pc_to_fetch
  );

  modport master (
    output alloc_valid_from_dispatcher,
    output alloc_rd_from_dispatcher,
    output alloc_is_branch_from_dispatcher,
    output alloc_pred_taken_from_dispatcher,
    output alloc_alt_pc_from_dispatcher,
    input  full_to_dispatcher,
    input  alloc_tag_to_dispatcher,
    output wb_valid_from_cdb,
    output wb_tag_from_cdb,
    output wb_value_from_cdb,
    output wb_taken_from_cdb,
    output query_tag1_from_dispatcher,
    output query_tag2_from_dispatcher,
    input  query_ready1_to_dispatcher,
    input  query_ready2_to_dispatcher,
    input  query_value1_to_dispatcher,
    input  query_value2_to_dispatcher,
    input  commit_flag_to_regfile,
    input  rd_to_regfile,
    input  Q_to_regfile,
    input  V_to_regfile,
    input  rollback_flag_to_regfile,
    input  rollback_pc_to_fetch
  );
endinterface

// File: rtl/rob_commit_ctrl.sv
// Reorder buffer with in-order commit and branch-mispredict rollback.
// Tag = entry index + 1; tag 0 means "no producer".
module rob_commit_ctrl #(
  parameter int unsigned ROB_SIZE = 16,
  parameter int unsigned PTR_W    = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  rob_commit_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [CNT_W-1:0]    count;
  logic [ROB_SIZE-1:0] busy;
  logic [ROB_SIZE-1:0] ready;
  logic [ROB_SIZE-1:0] is_br;
  logic [ROB_SIZE-1:0] pred;
  logic [ROB_SIZE-1:0] tkn;
  logic [4:0]          rd_q  [ROB_SIZE];
  logic [31:0]         val_q [ROB_SIZE];
  logic [31:0]         alt_q [ROB_SIZE];

  logic             full;
  logic             head_rdy;
  logic             mispred;
  logic             do_commit;
  logic             do_alloc;
  logic             wb_hit;
  logic [PTR_W-1:0] wb_idx;
  logic [PTR_W-1:0] q1_idx;
  logic [PTR_W-1:0] q2_idx;
  logic             q1_ok;
  logic             q2_ok;
  logic [PTR_W-1:0] head_nxt;
  logic [PTR_W-1:0] tail_nxt;

  function automatic logic [PTR_W-1:0] tag_idx(input logic [4:0] t);
    return PTR_W'(t - 5'd1);
  endfunction

  function automatic logic tag_ok(input logic [4:0] t);
    return (t != 5'd0) && (32'(t) <= ROB_SIZE);
  endfunction

  always_comb begin
    full      = (count == CNT_W'(ROB_SIZE));
    head_rdy  = (count != '0) && busy[head] && ready[head];
    mispred   = head_rdy && is_br[head] && (tkn[head] != pred[head]);
    do_commit = head_rdy && !mispred;
    do_alloc  = bus.alloc_valid_from_dispatcher && !full && !mispred;

    wb_idx = tag_idx(bus.wb_tag_from_cdb);
    wb_hit = bus.wb_valid_from_cdb && tag_ok(bus.wb_tag_from_cdb)
             && busy[wb_idx];

    q1_idx = tag_idx(bus.query_tag1_from_dispatcher);
    q2_idx = tag_idx(bus.query_tag2_from_dispatcher);
    q1_ok  = tag_ok(bus.query_tag1_from_dispatcher)
             && busy[q1_idx] && ready[q1_idx];
    q2_ok  = tag_ok(bus.query_tag2_from_dispatcher)
             && busy[q2_idx] && ready[q2_idx];

    head_nxt = (head == PTR_W'(ROB_SIZE - 1)) ? '0 : head + PTR_W'(1);
    tail_nxt = (tail == PTR_W'(ROB_SIZE - 1)) ? '0 : tail + PTR_W'(1);
  end

  assign bus.full_to_dispatcher         = full;
  assign bus.alloc_tag_to_dispatcher    = 5'(tail) + 5'd1;
  assign bus.query_ready1_to_dispatcher = q1_ok;
  assign bus.query_ready2_to_dispatcher = q2_ok;
  assign bus.query_value1_to_dispatcher = q1_ok ? val_q[q1_idx] : '0;
  assign bus.query_value2_to_dispatcher = q2_ok ? val_q[q2_idx] : '0;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      ready <= '0;
      bus.commit_flag_to_regfile   <= 1'b0;
      bus.rd_to_regfile            <= '0;
      bus.Q_to_regfile             <= '0;
      bus.V_to_regfile             <= '0;
      bus.rollback_flag_to_regfile <= 1'b0;
      bus.rollback_pc_to_fetch     <= '0;
    end else if (!rdy_in) begin
      bus.commit_flag_to_regfile   <= 1'b0;
      bus.rollback_flag_to_regfile <= 1'b0;
    end else begin
      bus.commit_flag_to_regfile   <= do_commit;
      bus.rollback_flag_to_regfile <= mispred;
      if (wb_hit) begin
        ready[wb_idx] <= 1'b1;
        val_q[wb_idx] <= bus.wb_value_from_cdb;
        tkn[wb_idx]   <= bus.wb_taken_from_cdb;
      end
      if (do_commit) begin
        bus.rd_to_regfile <= rd_q[head];
        bus.Q_to_regfile  <= 5'(head) + 5'd1;
        bus.V_to_regfile  <= val_q[head];
        busy[head]        <= 1'b0;
        ready[head]       <= 1'b0;
        head              <= head_nxt;
      end
      if (do_alloc) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
        rd_q[tail]  <= bus.alloc_rd_from_dispatcher;
        is_br[tail] <= bus.alloc_is_branch_from_dispatcher;
        pred[tail]  <= bus.alloc_pred_taken_from_dispatcher;
        alt_q[tail] <= bus.alloc_alt_pc_from_dispatcher;
        tail        <= tail_nxt;
      end
      if (do_alloc && !do_commit)
        count <= count + CNT_W'(1);
      else if (do_commit && !do_alloc)
        count <= count - CNT_W'(1);
      // A mispredict flushes everything, overriding this edge's updates.
      if (mispred) begin
        bus.rollback_pc_to_fetch <= alt_q[head];
        head  <= '0;
        tail  <= '0;
        count <= '0;
        busy  <= '0;
        ready <= '0;
      end
    end
  end

endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- Reorder buffer and in-order commit sequencer for the architectural register file.
- Hands rename tags to the dispatcher, collects results from the common data bus (CDB), and retires entries in program order.
- On retire, drives the register file's commit port (commit flag, rd, tag, value).
- On a mispredicted branch at the head, drives the register file's rollback flag and a redirect PC, then flushes itself.

Parameters:
- ROB_SIZE, 16, number of entries. Must be ≤31, because tags are 5 bits and tag 0 means "no producer".
- PTR_W, 4, log2(ROB_SIZE), width of the head/tail pointers.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge
- rst_in  input  1  synchronous, active-high reset
- rdy_in  input  1  global enable; when low, all state holds
- alloc_valid_from_dispatcher  input  1  request to allocate one entry this cycle
- alloc_rd_from_dispatcher  input  5  destination register; 0 for stores and branches
- alloc_is_branch_from_dispatcher  input  1  entry is a conditional branch
- alloc_pred_taken_from_dispatcher  input  1  predicted direction
- alloc_alt_pc_from_dispatcher  input  32  redirect PC if the prediction is wrong
- full_to_dispatcher  output  1  combinational; count == ROB_SIZE
- alloc_tag_to_dispatcher  output  5  combinational; tail index + 1, i.e. the tag the next allocation receives
- wb_valid_from_cdb  input  1  result broadcast valid
- wb_tag_from_cdb  input  5  tag of the producing entry
- wb_value_from_cdb  input  32  result value
- wb_taken_from_cdb  input  1  actual branch outcome (ignored for non-branches)
- query_tag1_from_dispatcher, query_tag2_from_dispatcher  input  5  tags to probe for operand forwarding
- query_ready1_to_dispatcher, query_ready2_to_dispatcher  output  1  combinational; entry holds a value
- query_value1_to_dispatcher, query_value2_to_dispatcher  output  32  combinational; that entry's value
- commit_flag_to_regfile  output  1  registered one-cycle pulse
- rd_to_regfile  output  5  registered
- Q_to_regfile  output  5  registered; tag of the retired entry
- V_to_regfile  output  32  registered
- rollback_flag_to_regfile  output  1  registered one-cycle pulse; also consumed by the fetch unit and the reservation stations
- rollback_pc_to_fetch  output  32  registered; valid while rollback_flag_to_regfile is high

Behaviour:
- Reset (rst_in high at an edge):
  - head = tail = count = 0; all entry busy and ready bits cleared.
  - All registered outputs go to 0.
  - Reset overrides every other input, including in the middle of a rollback or a commit.
- rdy_in low: no state changes. commit_flag and rollback_flag are driven 0 on the following edge. Combinational outputs still reflect the held state.
- Entry fields: busy, ready, rd, value, is_branch, pred_taken, taken, alt_pc. Tag = index + 1.
- Allocation:
  - Taken when alloc_valid and count < ROB_SIZE and no rollback is being generated this edge.
  - Writes the entry at tail with busy=1, ready=0; tail wraps from ROB_SIZE-1 to 0.
  - An allocation while full is ignored; the dispatcher must not assert alloc_valid while full_to_dispatcher is high.
- Writeback: when wb_valid and the tagged entry is busy, sets ready=1 and stores value and taken. A writeback to a non-busy entry or to tag 0 is ignored.
- Query: ready = entry busy && ready. When tag is 0 or the entry is not busy, ready=0 and value=0. Query does not forward a same-cycle CDB value; the dispatcher snoops the CDB itself.
- Commit (one entry per edge at most), when count > 0 and the head entry is ready at the start of the cycle:
  - Not a branch, or branch with taken == pred_taken:
    - commit_flag=1; rd, Q=head+1, V=value.
    - Clear busy at head; head advances with wrap.
    - For branches rd is 0, so the register file ignores the value.
  - Branch with taken != pred_taken:
    - rollback_flag=1 and rollback_pc=alt_pc; commit_flag=0.
    - All entries flushed: head = tail = count = 0, all busy cleared.
    - Same-edge allocation and writeback are discarded.
- Latency:
  - A writeback at edge N is committed at edge N+1 at the earliest; commit_flag is visible after edge N+1.
  - An allocation at edge N can be committed no earlier than edge N+2.
- count update on the same edge:
  - count += alloc_accepted − commit_accepted.
  - Allocate and commit on the same edge leave count unchanged.
  - full is evaluated before the edge, so a commit does not free space for a same-edge allocation.
- commit_flag and rollback_flag are never high in the same cycle.

Test Plan:
- Reset, then ALU op allocated with rd=5 (tag 1) → writeback tag 1, value 0x1234 → next edge commit_flag=1, rd=5, Q=1, V=0x1234; count returns to 0.
- Out-of-order writeback: allocate tags 1, 2, 3; write back 3, then 2, then 1 → commits occur for tags 1, 2, 3 on consecutive edges, in that order.
- Fill 16 entries → full=1, alloc_tag=1 (tail wrapped); a 17th alloc_valid is ignored; after one commit, the next allocation receives tag 1.
- Branch at head with pred_taken=0 and CDB taken=1, alt_pc=0x100, with 5 younger entries → rollback_flag pulse, rollback_pc=0x100, no commit_flag; next cycle full=0 and alloc_tag=1.
- rdy_in low for 3 cycles while the head is ready → no commit and pointers held; commit occurs on the first edge after rdy_in returns high.
- Reset asserted in the cycle after a rollback and again during a pending commit → all outputs 0 and count=0 on the next edge.
